// File: rtl/core_host_cmd_mailbox_if.sv
// Bridge and core-side signal bundle for the host command mailbox.
// master: bridge host + command-issuing core logic; slave: the mailbox block.
interface core_host_cmd_mailbox_if #(
    parameter int NUM_PARAMS = 8
);
    logic [31:0]              bridge_addr;
    logic                     bridge_wr;
    logic [31:0]              bridge_wr_data;
    logic                     bridge_rd;
    logic [31:0]              bridge_rd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [15:0]              cmd_id;
    logic [32*NUM_PARAMS-1:0] cmd_param;
    logic                     rsp_valid;
    logic [15:0]              rsp_result;
    logic                     rsp_timeout;
    logic                     busy;

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        output cmd_valid, cmd_id, cmd_param,
        input  bridge_rd_data, cmd_ready, rsp_valid, rsp_result, rsp_timeout, busy
    );

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        input  cmd_valid, cmd_id, cmd_param,
        output bridge_rd_data, cmd_ready, rsp_valid, rsp_result, rsp_timeout, busy
    );
endinterface

// File: rtl/core_host_cmd_mailbox.sv
// Core-to-host command mailbox on the APF bridge.
// The core posts id + params; the host polls word 0, executes, and acks on word 1.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  IDLE      | mailbox empty, cmd_ready high
//  WAIT_HOST | command posted, waiting for host ack or timeout
//  RESP      | one-cycle rsp_valid pulse, mailbox cleared on exit
module core_host_cmd_mailbox #(
    parameter logic [31:0] ADDR_BASE   = 32'hF8001000,
    parameter int          NUM_PARAMS  = 8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd74250000
) (
    input logic                    clk_74a,
    input logic                    reset_n,
    core_host_cmd_mailbox_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_HOST, RESP} state_t;

    localparam logic [15:0] REQ_MAGIC = 16'h636D;
    localparam logic [15:0] ACK_MAGIC = 16'h6F6B;
    localparam logic [29:0] NUM_WORDS = 30'(2 + NUM_PARAMS);

    state_t      state_q, state_d;
    logic [31:0] req_word_q;
    logic [31:0] param_q [NUM_PARAMS];
    logic [31:0] timer_q;
    logic [15:0] result_q;
    logic        timeout_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_word;

    logic [31:0] offset;
    logic [29:0] word_idx;
    logic        addr_hit;
    logic        ack_hit;
    logic        expire;

    // Subtracting the base lets addresses below it wrap out of range.
    assign offset   = bus.bridge_addr - ADDR_BASE;
    assign word_idx = offset[31:2];
    assign addr_hit = (offset[1:0] == 2'b00) && (word_idx < NUM_WORDS);

    assign ack_hit = (state_q == WAIT_HOST) && bus.bridge_wr && addr_hit &&
                     (word_idx == 30'd1) && (bus.bridge_wr_data[31:16] == ACK_MAGIC);
    assign expire  = (state_q == WAIT_HOST) && (TIMEOUT_CYC != 32'd0) &&
                     (timer_q == TIMEOUT_CYC - 32'd1);

    assign bus.bridge_rd_data = rd_data_q;
    assign bus.rsp_result     = result_q;
    assign bus.rsp_timeout    = timeout_q;

    // State register.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_d = WAIT_HOST;
            end
            WAIT_HOST: begin
                if (ack_hit || expire) state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mailbox contents: loaded on accept, cleared as the response is issued.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            req_word_q <= '0;
            for (int k = 0; k < NUM_PARAMS; k++) param_q[k] <= '0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            req_word_q <= {REQ_MAGIC, bus.cmd_id};
            for (int k = 0; k < NUM_PARAMS; k++) param_q[k] <= bus.cmd_param[32*k +: 32];
        end else if (state_q == RESP) begin
            req_word_q <= '0;
            for (int k = 0; k < NUM_PARAMS; k++) param_q[k] <= '0;
        end
    end

    // Saturating wait timer, cleared when a command is accepted.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            timer_q <= '0;
        end else if (state_q == WAIT_HOST && timer_q != 32'hFFFF_FFFF) begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Response capture; a valid ack takes priority over a coincident expiry.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else if (ack_hit) begin
            result_q  <= bus.bridge_wr_data[15:0];
            timeout_q <= 1'b0;
        end else if (expire) begin
            result_q  <= '0;
            timeout_q <= 1'b1;
        end
    end

    // Read decode; word 1 is write-only and reads back as zero.
    always_comb begin
        rd_word = '0;
        if (addr_hit) begin
            if (word_idx == 30'd0) rd_word = req_word_q;
            for (int k = 0; k < NUM_PARAMS; k++) begin
                if (word_idx == 30'(k + 2)) rd_word = param_q[k];
            end
        end
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n)          rd_data_q <= '0;
        else if (bus.bridge_rd) rd_data_q <= rd_word;
    end
endmodule

// File: tb/tb_core_host_cmd_mailbox.sv
// Self-checking bench for core_host_cmd_mailbox: expected responses are queued
// as stimulus is driven and matched against each rsp_valid pulse.
module tb_core_host_cmd_mailbox;
    localparam int          NP   = 4;
    localparam logic [31:0] BASE = 32'hF8001000;
    localparam logic [31:0] W0   = BASE;
    localparam logic [31:0] W1   = BASE + 32'd4;

    logic clk_74a = 1'b0;
    logic reset_n;

    always #5 clk_74a = ~clk_74a;

    core_host_cmd_mailbox_if #(.NUM_PARAMS(NP)) bus ();

    core_host_cmd_mailbox #(
        .ADDR_BASE  (BASE),
        .NUM_PARAMS (NP),
        .TIMEOUT_CYC(32'd100)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [15:0] result;
        logic        timeout;
        int          at_cycle;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk_74a) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [15:0] r, input logic t, input int at);
        rsp_t e;
        e.result   = r;
        e.timeout  = t;
        e.at_cycle = at;
        exp_q.push_back(e);
    endtask

    // Response monitor: every pulse must match the head of the queue.
    always @(negedge clk_74a) begin
        if (bus.rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rsp_result", {16'd0, bus.rsp_result}, {16'd0, mon_e.result});
                chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, mon_e.timeout});
                chk("rsp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
                if (mon_e.at_cycle >= 0) chk("rsp_cycle", 32'(cyc), 32'(mon_e.at_cycle));
            end
        end
    end

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk_74a); #1;
        bus.bridge_addr = addr;
        bus.bridge_rd   = 1'b1;
        @(posedge clk_74a); #1;
        bus.bridge_rd   = 1'b0;
        @(negedge clk_74a);
        data = bus.bridge_rd_data;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk_74a); #1;
        bus.bridge_addr    = addr;
        bus.bridge_wr_data = data;
        bus.bridge_wr      = 1'b1;
        @(posedge clk_74a); #1;
        bus.bridge_wr      = 1'b0;
    endtask

    task automatic post_cmd(input logic [15:0] id, input logic [32*NP-1:0] p, output int entry);
        @(posedge clk_74a); #1;
        chk("cmd_ready_pre", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_id    = id;
        bus.cmd_param = p;
        @(posedge clk_74a); #1;
        bus.cmd_valid = 1'b0;
        entry = cyc;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_74a);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          entry;

        bus.bridge_addr    = '0;
        bus.bridge_wr      = 1'b0;
        bus.bridge_wr_data = '0;
        bus.bridge_rd      = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_id         = '0;
        bus.cmd_param      = '0;
        reset_n            = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk_74a);
        #1;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rd_data", bus.bridge_rd_data, 32'd0);
        reset_n = 1'b1;
        bus_read(W0, rd);         chk("rst_w0", rd, 32'd0);
        bus_read(W1, rd);         chk("rst_w1", rd, 32'd0);
        bus_read(BASE + 8, rd);   chk("rst_w2", rd, 32'd0);

        // 2: post with a read in the accept cycle, then good ack
        @(posedge clk_74a); #1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_id      = 16'h0080;
        bus.cmd_param   = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF};
        bus.bridge_addr = W0;
        bus.bridge_rd   = 1'b1;
        @(posedge clk_74a); #1;
        bus.cmd_valid = 1'b0;
        bus.bridge_rd = 1'b0;
        @(negedge clk_74a);
        chk("w0_accept_cycle", bus.bridge_rd_data, 32'd0);
        chk("busy_wait", {31'd0, bus.busy}, 32'd1);
        chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd0);
        bus_read(W0, rd);          chk("w0_req", rd, 32'h636D_0080);
        bus_read(W1, rd);          chk("w1_reads_zero", rd, 32'd0);
        bus_read(BASE + 8, rd);    chk("w2_p0", rd, 32'hDEAD_BEEF);
        bus_read(BASE + 12, rd);   chk("w3_p1", rd, 32'h2222_0002);
        bus_read(BASE + 20, rd);   chk("w5_p3", rd, 32'h4444_0004);
        bus_read(BASE + 24, rd);   chk("w6_unmapped", rd, 32'd0);
        push_exp(16'h0001, 1'b0, -1);
        bus_write(W1, 32'h6F6B_0001);
        wait_rsp("ack1");
        bus_read(W0, rd);          chk("w0_cleared", rd, 32'd0);
        bus_read(BASE + 8, rd);    chk("w2_cleared", rd, 32'd0);
        chk("busy_after", {31'd0, bus.busy}, 32'd0);

        // 3: bad magic ignored, then good ack
        post_cmd(16'h0003, {32'd0, 32'd0, 32'd0, 32'h0000_0033}, entry);
        bus_write(W1, 32'h1234_0005);
        repeat (3) @(negedge clk_74a);
        chk("bad_magic_busy", {31'd0, bus.busy}, 32'd1);
        push_exp(16'h0005, 1'b0, -1);
        bus_write(W1, 32'h6F6B_0005);
        wait_rsp("ack5");

        // 4: timeout, exactly 100 cycles after entry
        post_cmd(16'h0044, {32'd0, 32'd0, 32'd0, 32'h0000_0044}, entry);
        push_exp(16'h0000, 1'b1, entry + 100);
        wait_rsp("timeout");
        @(negedge clk_74a);
        chk("hold_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
        chk("hold_result_to", {16'd0, bus.rsp_result}, 32'd0);

        // 5: ack on the expiry cycle wins
        post_cmd(16'h0055, {32'd0, 32'd0, 32'd0, 32'h0000_0055}, entry);
        push_exp(16'h0077, 1'b0, entry + 100);
        repeat (98) @(posedge clk_74a);
        bus_write(W1, 32'h6F6B_0077);
        wait_rsp("ack_on_expiry");
        @(negedge clk_74a);
        chk("hold_result", {16'd0, bus.rsp_result}, 32'h0000_0077);

        // 6: reset mid-wait aborts silently; next command completes; idle ack ignored
        post_cmd(16'h0066, {32'd0, 32'd0, 32'd0, 32'h0000_0066}, entry);
        repeat (5) @(posedge clk_74a);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk_74a); #1;
        reset_n = 1'b1;
        bus_read(W0, rd);          chk("abort_w0", rd, 32'd0);
        bus_read(BASE + 8, rd);    chk("abort_w2", rd, 32'd0);
        post_cmd(16'h0101, {32'd0, 32'd0, 32'd0, 32'h0000_0101}, entry);
        bus_read(W0, rd);          chk("w0_req2", rd, 32'h636D_0101);
        push_exp(16'h0022, 1'b0, -1);
        bus_write(W1, 32'h6F6B_0022);
        wait_rsp("ack22");
        bus_write(W1, 32'h6F6B_0009);
        repeat (3) @(negedge clk_74a);
        chk("idle_ack_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_ack_result", {16'd0, bus.rsp_result}, 32'h0000_0022);

        repeat (5) @(negedge clk_74a);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
